// File: rtl/mem_ctrl.sv
// Memory controller: MAR/MDR registers and read/write sequencing
// for a 512x32 RAM with one-cycle registered read latency.
module mem_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_bus_in,
    input  logic        i_mar_in,
    input  logic        i_mdr_in,
    input  logic        i_req,
    input  logic        i_rw,
    output logic [31:0] o_mdr_out,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_addr_oob,
    output logic [8:0]  o_ram_addr,
    output logic [31:0] o_ram_data_in,
    output logic        o_ram_we,
    input  logic [31:0] i_ram_data_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [8:0]  r_mar;
    logic [31:0] r_mdr;
    logic        r_oob;
    logic        r_busy;
    logic        r_done;
    logic        r_we;
    logic        w_load_ok;

    assign w_load_ok = (r_state == S_IDLE) || (r_state == S_DONE);

    // Flags are registered alongside the state they describe, so they
    // match a decode of r_state and clear asynchronously with it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_oob   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_we   <= 1'b0;
            if (w_load_ok && i_mar_in) begin
                r_mar <= i_bus_in[8:0];
                r_oob <= |i_bus_in[31:9];
            end
            if (w_load_ok && i_mdr_in) begin
                r_mdr <= i_bus_in;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_busy  <= 1'b1;
                        r_we    <= i_rw;
                        r_state <= i_rw ? S_WR : S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    r_busy  <= 1'b1;
                    r_state <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    r_mdr   <= i_ram_data_out;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_WR: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mdr_out     = r_mdr;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_addr_oob    = r_oob;
    assign o_ram_addr    = r_mar;
    assign o_ram_data_in = r_mdr;
    assign o_ram_we      = r_we;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the CPU datapath bus and the 512x32 synchronous-read RAM. Holds the memory address register (MAR) and memory data register (MDR). Sequences read and write requests through a small FSM that absorbs the RAM's one-cycle registered read latency. The datapath sees a simple req/done handshake and MDR contents on `mdr_out`.

## Interface
- No parameters. Depth is fixed at 512 words, address at 9 bits, data at 32 bits.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `bus_in`  in  32  datapath bus value.
- `mar_in`  in  1  load MAR from `bus_in[8:0]`.
- `mdr_in`  in  1  load MDR from `bus_in`.
- `req`  in  1  start a memory operation.
- `rw`  in  1  operation type, sampled with `req`: 1 = write, 0 = read.
- `mdr_out`  out  32  current MDR contents.
- `busy`  out  1  operation in progress; new requests and register loads are ignored.
- `done`  out  1  one-cycle pulse when the operation completes.
- `addr_oob`  out  1  set when the last MAR load had a nonzero `bus_in[31:9]`.
- `ram_addr`  out  9  to RAM `addr`; always equals MAR.
- `ram_data_in`  out  32  to RAM `data_in`; always equals MDR.
- `ram_we`  out  1  to RAM `write_enable`.
- `ram_data_out`  in  32  from RAM `data_out`; registered inside the RAM.

## Operation
- **States:** IDLE, RD_WAIT, RD_CAP, WR, DONE.
- **IDLE:**
  - `req`=1 and `rw`=0 -> RD_WAIT.
  - `req`=1 and `rw`=1 -> WR.
  - otherwise stay in IDLE.
- **RD_WAIT:** RAM samples `ram_addr` at the closing edge. Always -> RD_CAP.
- **RD_CAP:** `ram_data_out` is valid. MDR <= `ram_data_out` at the closing edge. -> DONE.
- **WR:** `ram_we`=1, so the RAM writes MDR to MAR at the closing edge. -> DONE.
- **DONE:** `done`=1. `req` is ignored. -> IDLE.
- **Register loads:** `mar_in` and `mdr_in` take effect only in IDLE or DONE. They are ignored while `busy`=1.
- **MAR load:** MAR <= `bus_in[8:0]`, i.e. address wraps modulo 512. At the same edge, `addr_oob` <= (`bus_in[31:9]` != 0). `addr_oob` holds until the next accepted MAR load.
- **Same-edge load and request in IDLE:** `mar_in`/`mdr_in` together with `req` in IDLE loads the registers at that edge. The operation then uses the newly loaded values.
- **MDR write conflict:** `mdr_in` and RD_CAP can never coincide, because loads are blocked while busy.
- **Combinational outputs:**
  - `busy` = state in {RD_WAIT, RD_CAP, WR}.
  - `done` = (state == DONE).
  - `ram_we` = (state == WR).

## Timing
- **Reset values:** state IDLE; MAR=0, MDR=0; `addr_oob`=0, `busy`=0, `done`=0, `ram_we`=0; `ram_addr`=0, `ram_data_in`=0, `mdr_out`=0.
- **Reset mid-operation:** the operation aborts immediately. `ram_we` falls asynchronously, so a WR interrupted before its closing edge writes nothing. A read interrupted before RD_CAP's edge leaves MDR at 0 (the reset value).
- **Read latency:** `req` sampled at edge E0.
  - RD_WAIT during E0–E1.
  - RD_CAP during E1–E2.
  - MDR updated at E2; `done`=1 during E2–E3.
  - Next request accepted at E4 at the earliest (IDLE during E3–E4).
- **Write latency:** `req` sampled at E0.
  - WR during E0–E1; memory updated at E1.
  - `done`=1 during E1–E2.
- **`busy`** is high for exactly 2 cycles per read and 1 cycle per write.
- **`req`** held high continuously starts a new operation every 4 cycles for reads and every 3 cycles for writes.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle -> all outputs 0 immediately; state IDLE.
- **Write then read:**
  - Load MAR=5, MDR=0xDEADBEEF; `req`=1, `rw`=1 -> `ram_we`=1 for one cycle; `done` one cycle later.
  - Then load MDR=0; `req`=1, `rw`=0 -> `mdr_out`=0xDEADBEEF two edges after `req`, with `done` in the same cycle.
- **Same-edge load and request:** `mar_in` (`bus_in`=0x1FF) with `req`=1, `rw`=1, MDR=0x12345678 -> RAM[511]=0x12345678. A subsequent read of 511 returns it.
- **Wrap and out-of-bounds:** `mar_in` with `bus_in`=0x00000203 -> MAR=3, `addr_oob`=1. Next `mar_in` with 0x7 -> `addr_oob`=0.
- **Ignored inputs while busy:** `req`, `mar_in`, `mdr_in` pulsed during RD_WAIT/RD_CAP -> no new operation; MAR/MDR unchanged except the RD_CAP capture; exactly one `done`.
- **Reset during WR:** assert `reset` during the WR cycle before its edge -> target word keeps its old value on read-back.
